mux_nx1_pipe: RTL and testbench
===============================

Name: mux_nx1_pipe

Overview:
- Parametrised, registered N-to-1 operand/result selector for the 32-bit ALU datapath; next generation of the fixed 4:1 32-bit word mux.
- Generalised in width and input count.
- Adds a valid/ready handshake with a 2-entry skid buffer, so it can sit between ALU stages at full throughput with fully registered outputs.
- Flags illegal select codes instead of passing undefined data.

Parameters:
- WIDTH, 32, data width per input in bits (≥1).
- NUM_IN, 4, number of selectable inputs (≥2).
- SEL_W, $clog2(NUM_IN), select width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  select code, sampled with the beat.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- out_data  out  WIDTH  selected word, registered.
- out_sel  out  SEL_W  select code that produced out_data.
- out_err  out  1  beat carried an illegal select (in_sel ≥ NUM_IN).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.

Behaviour:
- Reset is async on rst_n low and applies mid-transfer with no drain; any held beats are discarded.
- Reset values: out_data=0, out_sel=0, out_err=0, out_valid=0, skid empty, in_ready=1.
- Accept: a beat transfers in when in_valid && in_ready at the rising edge.
- Emit: a beat transfers out when out_valid && out_ready at the rising edge.
- Selection: data = in_data[in_sel*WIDTH +: WIDTH] when in_sel < NUM_IN.
  - Otherwise data = 0 and err = 1.
  - The illegal beat is still accepted and emitted; it does not stall.
- Latency: 1 cycle. A beat accepted at edge t appears on out_* after edge t, provided the output register is empty or drained at t.
- Storage: main register (drives out_*) plus one skid register. in_ready = ~skid_valid, taken directly from a flop with no combinational path from out_ready.
- Per edge, with acc = accept and emt = emit:
  - main empty, acc: load main from input.
  - main full, emt, skid empty, acc: load main from input.
  - main full, emt, skid full: main takes skid; skid takes input if acc, else skid clears. acc is impossible here because in_ready=0.
  - main full, no emt, acc: input goes to skid; in_ready drops next cycle.
  - main full, emt, no acc, skid empty: out_valid falls.
- out_data, out_sel and out_err hold stable while out_valid && !out_ready (AXI-style stability).
- in_data/in_sel are don't-care when in_valid=0. out_data is don't-care when out_valid=0, but it holds the last value (no clearing).
- Throughput: 1 beat/cycle sustained while out_ready=1. Never drops or duplicates a beat. Order is preserved.
- A NUM_IN that is not a power of 2 leaves unused codes; they are handled as illegal.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_WIDTH=32
  - an ALU result-select enum (ADD, LOGIC, SHIFT, CMP) sized to SEL_W for NUM_IN=4
  - a clog2 helper for tools lacking $clog2
- One natural sub-module: alu_skid_buf, a WIDTH+SEL_W+1-bit 2-entry skid buffer carrying the handshake.
- mux_nx1_pipe keeps only the combinational select/error logic and instantiates the skid buffer.

Test Plan:
- Reset, then a single beat: NUM_IN=4, inputs {0x11111111, 0x22222222, 0x33333333, 0x44444444}, sel=2, in_valid=1 for one cycle, out_ready=1 → next cycle out_valid=1, out_data=0x33333333, out_sel=2, out_err=0.
- Streaming: sel 0,1,2,3 on 4 consecutive cycles with out_ready=1 → outputs 0x11111111..0x44444444 on 4 consecutive cycles; in_ready stays 1.
- Backpressure: out_ready=0 while 3 beats are offered → 2 beats accepted, in_ready=0 from the third cycle, out_data stable at beat 1. Raise out_ready → beats 1 then 2 emitted, in_ready returns to 1, no loss.
- Illegal select: NUM_IN=3, sel=3 → out_data=0, out_err=1, out_sel=3. The following legal beat sel=1 has out_err=0.
- Async reset mid-operation: main and skid full, assert rst_n=0 between clock edges → out_valid=0 immediately and in_ready=1. After release, no stale beat is emitted.
- Parameter sweep: WIDTH=8, NUM_IN=8, random sel/valid/ready for 10k cycles, checked against a scoreboard → in-order, lossless, correct data and error flags.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: word width, result-select codes and a
// clog2 helper for tools that lack $clog2.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  localparam int ALU_SEL_W = clog2(4);

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_SEL_ADD   = 2'd0,
    ALU_SEL_LOGIC = 2'd1,
    ALU_SEL_SHIFT = 2'd2,
    ALU_SEL_CMP   = 2'd3
  } alu_sel_e;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer with fully registered outputs; in_ready
// comes straight from a flop so there is no combinational ready path.
module alu_skid_buf #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;
  logic          main_valid;
  logic          skid_valid;
  logic          acc;
  logic          emt;

  assign in_ready  = ~skid_valid;
  assign out_data  = main_q;
  assign out_valid = main_valid;
  assign acc       = in_valid & ~skid_valid;
  assign emt       = main_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  // The skid holding register is reset as well, so a discarded beat can
  // never reappear after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || emt) begin
      // Main register is free this edge: refill from skid first to keep order.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (acc) begin
        main_q     <= in_data;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (acc) begin
      skid_q     <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/mux_nx1_pipe.sv
// Registered N-to-1 word selector with illegal-select flagging, feeding a
// two-entry skid buffer for full-throughput valid/ready operation.
module mux_nx1_pipe
  import alu_pkg::*;
#(
  parameter  int WIDTH  = ALU_WIDTH,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int DW = WIDTH + SEL_W + 1;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic [DW-1:0]    out_word;

  // NOTE: defaults first, then overrides, so no path leaves a variable
  // unassigned and no latch is inferred.
  // Codes at or above NUM_IN match no input and fall through as zero data
  // with the error flag set.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(in_sel) == k) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  alu_skid_buf #(
    .DW(DW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  ({sel_data, in_sel, sel_err}),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_word),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign {out_data, out_sel, out_err} = out_word;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed and randomised bench for mux_nx1_pipe across three configurations:
// 4x32 (main), 3x32 (illegal codes) and 8x8 (random sweep with scoreboard).
module tb_mux_nx1_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] a_in_data;
  logic [1:0]   a_in_sel;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [31:0]  a_out_data;
  logic [1:0]   a_out_sel;

  logic [95:0]  b_in_data;
  logic [1:0]   b_in_sel;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [31:0]  b_out_data;
  logic [1:0]   b_out_sel;

  logic [63:0]  c_in_data;
  logic [2:0]   c_in_sel;
  logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err;
  logic [7:0]   c_out_data;
  logic [2:0]   c_out_sel;

  mux_nx1_pipe #(.WIDTH(32), .NUM_IN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
    .out_sel(a_out_sel), .out_err(a_out_err), .out_valid(a_out_valid),
    .out_ready(a_out_ready));

  mux_nx1_pipe #(.WIDTH(32), .NUM_IN(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_err(b_out_err), .out_valid(b_out_valid),
    .out_ready(b_out_ready));

  mux_nx1_pipe #(.WIDTH(8), .NUM_IN(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_sel(c_in_sel),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
    .out_sel(c_out_sel), .out_err(c_out_err), .out_valid(c_out_valid),
    .out_ready(c_out_ready));

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        err_b;
  } vec_t;

  vec_t vecs[8];

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];
  logic [11:0] exp_word;
  logic [63:0] c_word;
  int          c_sel_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{2'd0, 32'h11111111, 32'hAAAA0000, 1'b0};
    vecs[1] = '{2'd1, 32'h22222222, 32'hBBBB0001, 1'b0};
    vecs[2] = '{2'd2, 32'h33333333, 32'hCCCC0002, 1'b0};
    vecs[3] = '{2'd3, 32'h44444444, 32'h00000000, 1'b1};
    vecs[4] = '{2'd3, 32'h44444444, 32'h00000000, 1'b1};
    vecs[5] = '{2'd1, 32'h22222222, 32'hBBBB0001, 1'b0};
    vecs[6] = '{2'd2, 32'h33333333, 32'hCCCC0002, 1'b0};
    vecs[7] = '{2'd0, 32'h11111111, 32'hAAAA0000, 1'b0};

    a_in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    b_in_data = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    a_in_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_sel = '0; c_in_valid = 1'b0; c_out_ready = 1'b1;

    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_in_ready",  a_in_ready, 1);
    check("rst_a_out_data",  a_out_data, 0);
    check("rst_a_out_sel",   a_out_sel, 0);
    check("rst_a_out_err",   a_out_err, 0);
    check("rst_b_out_valid", b_out_valid, 0);

    // Single beat, one-cycle latency
    a_in_sel = ALU_SEL_SHIFT; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("single_valid", a_out_valid, 1);
    check("single_data",  a_out_data, 64'h33333333);
    check("single_sel",   a_out_sel, 2);
    check("single_err",   a_out_err, 0);
    step();
    check("single_drained", a_out_valid, 0);

    // Streaming table on both 4-input and 3-input instances
    for (int i = 0; i < 8; i++) begin
      a_in_sel = vecs[i].sel; a_in_valid = 1'b1;
      b_in_sel = vecs[i].sel; b_in_valid = 1'b1;
      step();
      check($sformatf("stream_a_valid[%0d]", i), a_out_valid, 1);
      check($sformatf("stream_a_data[%0d]", i),  a_out_data, vecs[i].exp_a);
      check($sformatf("stream_a_sel[%0d]", i),   a_out_sel, vecs[i].sel);
      check($sformatf("stream_a_err[%0d]", i),   a_out_err, 0);
      check($sformatf("stream_a_ready[%0d]", i), a_in_ready, 1);
      check($sformatf("stream_b_valid[%0d]", i), b_out_valid, 1);
      check($sformatf("stream_b_data[%0d]", i),  b_out_data, vecs[i].exp_b);
      check($sformatf("stream_b_sel[%0d]", i),   b_out_sel, vecs[i].sel);
      check($sformatf("stream_b_err[%0d]", i),   b_out_err, vecs[i].err_b);
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    step();
    check("stream_a_idle", a_out_valid, 0);
    check("stream_b_idle", b_out_valid, 0);
    check("stream_a_hold", a_out_data, vecs[7].exp_a);

    // Backpressure: three beats offered while downstream stalls
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_sel = 2'd0;
    step();
    check("bp1_valid", a_out_valid, 1);
    check("bp1_data",  a_out_data, 64'h11111111);
    check("bp1_ready", a_in_ready, 1);
    a_in_sel = 2'd1;
    step();
    check("bp2_data",  a_out_data, 64'h11111111);
    check("bp2_ready", a_in_ready, 0);
    a_in_sel = 2'd2;
    step();
    check("bp3_data",  a_out_data, 64'h11111111);
    check("bp3_sel",   a_out_sel, 0);
    check("bp3_ready", a_in_ready, 0);
    a_out_ready = 1'b1;
    step();
    check("bp4_data",  a_out_data, 64'h22222222);
    check("bp4_ready", a_in_ready, 1);
    step();
    a_in_valid = 1'b0;
    check("bp5_data",  a_out_data, 64'h33333333);
    check("bp5_valid", a_out_valid, 1);
    step();
    check("bp6_idle", a_out_valid, 0);

    // Async reset with main and skid both full
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_sel = 2'd3;
    step();
    a_in_sel = 2'd1;
    step();
    a_in_valid = 1'b0;
    check("prerst_ready", a_in_ready, 0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", a_out_valid, 0);
    check("arst_ready", a_in_ready, 1);
    check("arst_data",  a_out_data, 0);
    a_out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("postrst_valid[%0d]", i), a_out_valid, 0);
    end

    // Random sweep on the 8x8 instance against an in-order scoreboard
    for (int cyc = 0; cyc < 10000; cyc++) begin
      c_in_valid  = ($urandom_range(0, 3) != 0);
      c_out_ready = ($urandom_range(0, 3) != 0);
      c_in_sel    = 3'($urandom_range(0, 7));
      c_in_data   = {$urandom, $urandom};
      if (c_out_valid && c_out_ready) begin
        if (exp_q.size() == 0) begin
          check("sweep_unexpected_beat", 1, 0);
        end else begin
          exp_word = exp_q.pop_front();
          check("sweep_beat", {c_out_data, c_out_sel, c_out_err}, exp_word);
        end
      end
      if (c_in_valid && c_in_ready) begin
        c_word  = c_in_data;
        c_sel_i = int'(c_in_sel);
        exp_q.push_back({c_word[c_sel_i*8 +: 8], c_in_sel, 1'b0});
      end
      step();
    end
    c_in_valid = 1'b0; c_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c_out_valid) begin
        if (exp_q.size() == 0) begin
          check("drain_unexpected_beat", 1, 0);
        end else begin
          exp_word = exp_q.pop_front();
          check("drain_beat", {c_out_data, c_out_sel, c_out_err}, exp_word);
        end
      end
      step();
    end
    check("sweep_lossless", exp_q.size(), 0);
    check("sweep_idle", c_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
